// File: rtl/countdown_timer_ctlr_pkg.sv
// Shared constants for the countdown timer: add amounts, presets and widths.
package countdown_timer_ctlr_pkg;

    localparam int COUNT_W = 14;
    localparam int SUM_W   = 15;
    localparam int PRESC_W = 27;

    localparam logic [SUM_W-1:0]   ADD_U = 15'd10;
    localparam logic [SUM_W-1:0]   ADD_L = 15'd180;
    localparam logic [SUM_W-1:0]   ADD_R = 15'd200;
    localparam logic [SUM_W-1:0]   ADD_D = 15'd550;

    localparam logic [COUNT_W-1:0] MAX_COUNT = 14'd9999;
    localparam logic [COUNT_W-1:0] PRESET0   = 14'd15;
    localparam logic [COUNT_W-1:0] PRESET1   = 14'd185;

endpackage

// File: rtl/countdown_timer_ctlr_bin2bcd.sv
// Combinational 14-bit binary to 4-digit BCD converter (double-dabble).
module bin2bcd_14 (
    input  logic [13:0] bin_i,
    output logic [15:0] bcd_o
);

    logic [29:0] shift_v;

    // Shift the binary value in one bit at a time, correcting each digit >= 5 first.
    always_comb begin
        shift_v        = '0;
        shift_v[13:0]  = bin_i;
        for (int i = 0; i < 14; i++) begin
            for (int d = 0; d < 4; d++) begin
                if (shift_v[14 + 4*d +: 4] > 4'd4) begin
                    shift_v[14 + 4*d +: 4] = shift_v[14 + 4*d +: 4] + 4'd3;
                end
            end
            shift_v = shift_v << 1;
        end
        bcd_o = shift_v[29:14];
    end

endmodule

// File: rtl/countdown_timer_ctlr.sv
// Seconds countdown timer: button strobes add time, switches preset it,
// a prescaler decrements it once per tick; BCD/zero/blank feed the display.
module countdown_timer_ctlr
    import countdown_timer_ctlr_pkg::*;
#(
    parameter int TICK_CYCLES = 100000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pulse_btnu,
    input  logic        pulse_btnl,
    input  logic        pulse_btnr,
    input  logic        pulse_btnd,
    input  logic        sw0,
    input  logic        sw1,
    output logic [15:0] bcd,
    output logic        zero,
    output logic        blank
);

    localparam logic [PRESC_W-1:0] TICK_LAST = PRESC_W'(TICK_CYCLES - 1);
    localparam logic [PRESC_W-1:0] HALF_TICK = PRESC_W'(TICK_CYCLES / 2);

    logic [COUNT_W-1:0] count_q, count_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [3:0]         prev_q;
    logic [3:0]         pulse_v;
    logic [3:0]         edge_v;
    logic [SUM_W-1:0]   add_sum;
    logic [SUM_W-1:0]   sum_v;
    logic [COUNT_W-1:0] dec_count;
    logic               tick;

    // Bit order {d, r, l, u} throughout.
    assign pulse_v = {pulse_btnd, pulse_btnr, pulse_btnl, pulse_btnu};
    assign edge_v  = pulse_v & ~prev_q;

    // Sum of all rising-edge contributions this cycle (0..940).
    always_comb begin
        add_sum = '0;
        if (edge_v[0]) add_sum = add_sum + ADD_U;
        if (edge_v[1]) add_sum = add_sum + ADD_L;
        if (edge_v[2]) add_sum = add_sum + ADD_R;
        if (edge_v[3]) add_sum = add_sum + ADD_D;
    end

    // Next count and prescaler: switches win, otherwise decrement then saturating add.
    always_comb begin
        tick      = (presc_q == TICK_LAST);
        presc_d   = tick ? '0 : presc_q + 27'd1;
        dec_count = (tick && (count_q != '0)) ? count_q - 14'd1 : count_q;
        sum_v     = {1'b0, dec_count} + add_sum;
        count_d   = count_q;
        if (sw1) begin
            count_d = PRESET1;
            presc_d = '0;
        end else if (sw0) begin
            count_d = PRESET0;
            presc_d = '0;
        end else if (sum_v > {1'b0, MAX_COUNT}) begin
            count_d = MAX_COUNT;
        end else begin
            count_d = sum_v[COUNT_W-1:0];
        end
    end

    // State registers; prev samples every cycle so held strobes never re-add.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            presc_q <= '0;
            prev_q  <= '0;
        end else begin
            count_q <= count_d;
            presc_q <= presc_d;
            prev_q  <= pulse_v;
        end
    end

    assign zero  = (count_q == '0);
    assign blank = zero & (presc_q >= HALF_TICK);

    bin2bcd_14 u_bin2bcd (
        .bin_i (count_q),
        .bcd_o (bcd)
    );

endmodule

// File: tb/tb_countdown_timer_ctlr.sv
// Self-checking bench for countdown_timer_ctlr with TICK_CYCLES = 10.
module tb_countdown_timer_ctlr;

    localparam int TICK = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        pulse_btnu, pulse_btnl, pulse_btnr, pulse_btnd;
    logic        sw0, sw1;
    logic [15:0] bcd;
    logic        zero;
    logic        blank;

    countdown_timer_ctlr #(.TICK_CYCLES(TICK)) dut (
        .clk        (clk),
        .rst        (rst),
        .pulse_btnu (pulse_btnu),
        .pulse_btnl (pulse_btnl),
        .pulse_btnr (pulse_btnr),
        .pulse_btnd (pulse_btnd),
        .sw0        (sw0),
        .sw1        (sw1),
        .bcd        (bcd),
        .zero       (zero),
        .blank      (blank)
    );

    always #5 clk = ~clk;

    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          at;
        logic [15:0] bcd;
        logic        zero;
        logic        chk_blank;
        logic        blank;
        string       name;
    } exp_t;

    typedef struct {
        logic [3:0]  btn;
        logic        sw0;
        logic        sw1;
        int          n;
        logic [15:0] bcd;
        logic        zero;
        logic        chk_blank;
        logic        blank;
        string       name;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[11];

    task automatic compare(input string name, input logic [15:0] eb, input logic ez,
                           input logic cb, input logic ebl);
        checks++;
        if (bcd !== eb || zero !== ez || (cb && blank !== ebl)) begin
            errors++;
            $display("FAIL %s: got bcd=%h zero=%b blank=%b, expected bcd=%h zero=%b blank=%b%s",
                     name, bcd, zero, blank, eb, ez, ebl, cb ? "" : "(dc)");
        end
    endtask

    // Queue an expectation for the state after `dly` more rising edges.
    task automatic exp_after(input int dly, input logic [15:0] eb, input logic ez,
                             input logic cb, input logic ebl, input string name);
        exp_t e;
        int   i;
        e.at = cyc_n + dly; e.bcd = eb; e.zero = ez;
        e.chk_blank = cb; e.blank = ebl; e.name = name;
        i = 0;
        while (i < exp_q.size() && exp_q[i].at <= e.at) i++;
        exp_q.insert(i, e);
    endtask

    task automatic drain();
        exp_t e;
        while (exp_q.size() != 0 && exp_q[0].at <= cyc_n) begin
            e = exp_q.pop_front();
            compare(e.name, e.bcd, e.zero, e.chk_blank, e.blank);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            drain();
        end
    endtask

    task automatic set_btn(input logic [3:0] b);
        {pulse_btnd, pulse_btnr, pulse_btnl, pulse_btnu} = b;
    endtask

    initial begin
        //          btn    sw0   sw1   n    bcd       zero  cb    blank
        vecs[0]  = '{4'h0, 1'b1, 1'b0, 3,   16'h0015, 1'b0, 1'b1, 1'b0, "sw0_preset"};
        vecs[1]  = '{4'h0, 1'b0, 1'b0, 9,   16'h0015, 1'b0, 1'b0, 1'b0, "pre_first_tick"};
        vecs[2]  = '{4'h0, 1'b0, 1'b0, 1,   16'h0014, 1'b0, 1'b0, 1'b0, "first_tick"};
        vecs[3]  = '{4'h0, 1'b0, 1'b0, 150, 16'h0000, 1'b1, 1'b1, 1'b0, "run_to_zero"};
        vecs[4]  = '{4'h0, 1'b0, 1'b0, 5,   16'h0000, 1'b1, 1'b1, 1'b1, "zero_blank_hi"};
        vecs[5]  = '{4'h0, 1'b0, 1'b0, 5,   16'h0000, 1'b1, 1'b1, 1'b0, "zero_blank_lo"};
        vecs[6]  = '{4'h8, 1'b0, 1'b0, 1,   16'h0550, 1'b0, 1'b1, 1'b0, "btnd_add"};
        vecs[7]  = '{4'h8, 1'b0, 1'b0, 8,   16'h0550, 1'b0, 1'b0, 1'b0, "btnd_held"};
        vecs[8]  = '{4'h8, 1'b0, 1'b0, 1,   16'h0549, 1'b0, 1'b0, 1'b0, "btnd_held_tick"};
        vecs[9]  = '{4'h8, 1'b0, 1'b0, 40,  16'h0545, 1'b0, 1'b0, 1'b0, "btnd_held_once"};
        vecs[10] = '{4'h0, 1'b0, 1'b0, 10,  16'h0544, 1'b0, 1'b0, 1'b0, "btnd_released"};

        rst = 1'b1; sw0 = 1'b0; sw1 = 1'b0;
        set_btn(4'h0);

        // Reset state, then idle with blank following the prescaler.
        exp_after(1, 16'h0000, 1'b1, 1'b1, 1'b0, "reset_state");
        step(3);
        rst = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            exp_after(1, 16'h0000, 1'b1, 1'b1, ((k % TICK) >= 5), "idle_blank");
            step(1);
        end

        // Presets, decrement to zero, held strobe.
        for (int v = 0; v < 11; v++) begin
            set_btn(vecs[v].btn);
            sw0 = vecs[v].sw0;
            sw1 = vecs[v].sw1;
            exp_after(vecs[v].n, vecs[v].bcd, vecs[v].zero, vecs[v].chk_blank,
                      vecs[v].blank, vecs[v].name);
            step(vecs[v].n);
        end

        // Saturation with all four strobes at once.
        set_btn(4'h0);
        sw1 = 1'b1;
        exp_after(1, 16'h0185, 1'b0, 1'b0, 1'b0, "sw1_preset");
        step(2);
        sw1 = 1'b0;
        exp_after(9, 16'h4885, 1'b0, 1'b0, 1'b0, "all4_x5");
        exp_after(10, 16'h4884, 1'b0, 1'b0, 1'b0, "all4_x5_tick");
        for (int p = 0; p < 10; p++) begin
            set_btn((p % 2 == 0) ? 4'hF : 4'h0);
            step(1);
        end
        exp_after(9, 16'h9584, 1'b0, 1'b0, 1'b0, "all4_x10");
        exp_after(10, 16'h9583, 1'b0, 1'b0, 1'b0, "all4_x10_tick");
        for (int p = 0; p < 10; p++) begin
            set_btn((p % 2 == 0) ? 4'hF : 4'h0);
            step(1);
        end
        set_btn(4'hF);
        exp_after(1, 16'h9999, 1'b0, 1'b0, 1'b0, "saturate_9999");
        step(1);
        set_btn(4'h0);
        exp_after(8, 16'h9999, 1'b0, 1'b0, 1'b0, "saturate_hold");
        exp_after(9, 16'h9998, 1'b0, 1'b0, 1'b0, "saturate_tick");
        step(9);

        // Tick and add in the same cycle; switch priority; release-cycle edge.
        sw0 = 1'b1;
        exp_after(1, 16'h0015, 1'b0, 1'b0, 1'b0, "sw0_over_9998");
        step(1);
        sw0 = 1'b0;
        exp_after(99, 16'h0006, 1'b0, 1'b0, 1'b0, "count_6");
        exp_after(100, 16'h0005, 1'b0, 1'b0, 1'b0, "count_5");
        exp_after(109, 16'h0005, 1'b0, 1'b0, 1'b0, "count_5_pre_tick");
        step(109);
        pulse_btnu = 1'b1;
        exp_after(1, 16'h0014, 1'b0, 1'b0, 1'b0, "tick_and_add");
        step(1);
        pulse_btnu = 1'b0;
        step(1);
        sw0 = 1'b1; sw1 = 1'b1; pulse_btnr = 1'b1;
        exp_after(1, 16'h0185, 1'b0, 1'b0, 1'b0, "sw1_priority");
        step(1);
        sw0 = 1'b0; sw1 = 1'b0;
        exp_after(1, 16'h0185, 1'b0, 1'b0, 1'b0, "add_discarded");
        step(1);
        pulse_btnr = 1'b0;
        sw0 = 1'b1;
        exp_after(1, 16'h0015, 1'b0, 1'b0, 1'b0, "sw0_again");
        step(1);
        sw0 = 1'b0; pulse_btnu = 1'b1;
        exp_after(1, 16'h0025, 1'b0, 1'b0, 1'b0, "release_cycle_edge");
        step(1);
        pulse_btnu = 1'b0;

        // Reset mid-count with a strobe held through release.
        sw1 = 1'b1;
        step(1);
        sw1 = 1'b0; pulse_btnd = 1'b1;
        exp_after(1, 16'h0735, 1'b0, 1'b0, 1'b0, "count_735");
        step(1);
        pulse_btnd = 1'b0; pulse_btnl = 1'b1;
        exp_after(1, 16'h0915, 1'b0, 1'b0, 1'b0, "count_915");
        step(1);
        rst = 1'b1;
        #1;
        compare("rst_async", 16'h0000, 1'b1, 1'b1, 1'b0);
        exp_after(1, 16'h0000, 1'b1, 1'b1, 1'b0, "rst_held");
        step(2);
        rst = 1'b0;
        exp_after(1, 16'h0180, 1'b0, 1'b0, 1'b0, "rst_release_add");
        exp_after(6, 16'h0180, 1'b0, 1'b0, 1'b0, "no_second_add");
        exp_after(10, 16'h0179, 1'b0, 1'b0, 1'b0, "post_rst_tick");
        step(10);
        pulse_btnl = 1'b0;
        step(3);

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_expectations: %0d left, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/countdown_timer_ctlr.md
# countdown_timer_ctlr

Decrementing seconds timer that consumes the four debounced, single-pulsed button strobes produced by the project 4 button controller and turns them into time additions. It holds a binary count from 0 to 9999 seconds, decrements once per second, saturates at both ends, and supports switch presets of 15 s and 185 s. It exposes the count as four BCD digits plus a zero flag and a 1 Hz blank strobe for the 7-segment display driver.

## Interface

- TICK_CYCLES, 100000000: clk cycles per one-second tick. Must be ≥ 4 and even.
- clk  in  1  100 MHz system clock; all state is on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- pulse_btnu  in  1  button strobe: add 10 s.
- pulse_btnl  in  1  button strobe: add 180 s.
- pulse_btnr  in  1  button strobe: add 200 s.
- pulse_btnd  in  1  button strobe: add 550 s.
- sw0  in  1  level: preset count to 15 s. Active high.
- sw1  in  1  level: preset count to 185 s. Active high. Has priority over sw0.
- bcd  out  16  count in BCD: [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] ones.
- zero  out  1  high when count == 0.
- blank  out  1  high during the second half of each tick period while zero is high; the display driver blanks all digits when it is high.

## Operation

- State: count[13:0] (binary, 0..9999), presc[26:0] (0..TICK_CYCLES-1), and prev_u/l/r/d, which hold the previous sample of each strobe.
- Strobe inputs are synchronous to clk but can stay high for many cycles. Each input contributes only on its rising edge: edge_x = pulse_x & ~prev_x. prev_x <= pulse_x on every cycle, including during presets.
- add_sum = 10·edge_u + 180·edge_l + 200·edge_r + 550·edge_d (0..940). Simultaneous edges on different inputs sum.
- tick = (presc == TICK_CYCLES-1). presc increments each cycle and wraps to 0 after TICK_CYCLES-1.
- Next-state priority, highest first:
  - rst: count=0, presc=0, prev_*=0 (asynchronous).
  - sw1 high: count=185, presc=0. Edges are discarded, not deferred.
  - sw0 high: count=15, presc=0. Edges are discarded.
  - Otherwise: dec = (tick && count>0) ? count-1 : count, then count <= min(9999, dec + add_sum).
- Arithmetic: compute the sum in at least 15 bits before the saturating compare. count never exceeds 9999 and never underflows.
- At count==0 with no adds, count stays 0 and presc keeps running, which drives blank.
- Outputs:
  - bcd = binary-to-BCD of the registered count (combinational).
  - zero = (count == 0).
  - blank = zero & (presc ≥ TICK_CYCLES/2).

## Timing

- Reset values: count=0, so bcd=16'h0000 and zero=1. presc=0, so blank=0.
- Add latency: count reflects an add at the first rising clk edge where pulse_x is sampled high with prev_x low. The add is visible on bcd/zero one cycle after the strobe rises.
- Strobe held high: it adds exactly once. It must return low for at least one sampled cycle before it can add again.
- Decrement: the first decrement happens exactly TICK_CYCLES cycles after reset deassertion or switch release, then every TICK_CYCLES cycles.
- Tick and add in the same cycle: both apply, decrement first. Example: count 5, tick, edge_u gives 14.
- Switch release: the count runs from the preset value the next cycle. A strobe edge in the release cycle is counted only if the switch was sampled low that cycle.
- Reset mid-count or mid-strobe: the count clears immediately. If a strobe is still high when reset releases, it counts once, because prev was cleared.

## Structure

- Shared package: add constants (ADD_U=10, ADD_L=180, ADD_R=200, ADD_D=550), MAX_COUNT=9999, PRESET0=15, PRESET1=185, and COUNT_W=14.
- Sub-module bin2bcd_14: combinational 14-bit binary to 4-digit BCD (double-dabble). It is instantiated once and can be reused by other display blocks.
- Top level: edge detectors, prescaler, count register with priority mux, and output logic.

## Test plan

Run all scenarios with TICK_CYCLES=10.

1. Reset, then idle 25 cycles → bcd=0000, zero=1, and blank is high on cycles 5–9 and 15–19 of each period.
2. sw0 high 3 cycles then low → bcd=0015. After 10 cycles bcd=0014. After 150 more cycles bcd=0000, zero=1, and the count stays at 0.
3. From count 0, hold pulse_btnd high 50 cycles → exactly one add. bcd=0550 one cycle after the rise, then decrements normally.
4. Raise all four strobes in the same cycle from count 9500 → bcd=9999, saturated, not 10440. The next tick gives 9998.
5. From count 5, align edge_u with tick → bcd=0014. sw1 and sw0 high together with a strobe edge → bcd=0185, and the add is discarded.
6. Assert rst while pulse_btnl is high and count=0700 → bcd=0000 immediately. Release rst with the strobe still high → bcd=0180 after one cycle, with no second add.
